idct8_2d_seq: RTL and testbench
===============================

# idct8_2d_seq

Sequencer that computes a full 8x8 2-D inverse DCT with a single shared 1-D 8-point IDCT core (IDCT8_whole class), run as a row pass then a column pass. It accepts eight coefficient rows over a valid/ready handshake and drives them into the core. It captures the core results in an internal 8x8 transpose buffer, then replays the buffer columns through the same core and streams the eight column results out. It sits between the coefficient dequantiser and the reconstruction adder.

## Interface
- W, 25: sample width, signed two's complement, all lanes.
- CORE_LAT, 2: core latency in clock edges, 1..8. core_dout sampled at edge e+CORE_LAT reflects core_din registered at edge e.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- in_data  in  8*W  coefficient row; lane k = bits [k*W +: W] = column k.
- in_valid  in  1  row present.
- in_ready  out  1  row accepted at edges where in_valid && in_ready.
- core_din  out  8*W  registered operand to the IDCT8 core.
- core_vld  out  1  registered; high for the cycle core_din holds a new operand.
- core_dout  in  8*W  core result.
- out_data  out  8*W  column result; lane k = output pixel row k.
- out_col  out  3  column index 0..7 of out_data.
- out_valid  out  1  single-cycle strobe per column; no backpressure.
- blk_done  out  1  pulses together with out_valid for column 7.
- busy  out  1  high in every state except IDLE and LOAD.

## Operation
- States: IDLE, LOAD, WAIT_ROW, COL, WAIT_COL.
- Reset: state IDLE; all outputs 0; row/column counters 0; delay line cleared. Buffer contents undefined.
- IDLE -> LOAD unconditionally at the first edge after reset release.
- in_ready = (state == LOAD).
- LOAD: each handshake registers in_data into core_din, sets core_vld=1, and pushes tag {pass=row, idx=row_cnt} into a CORE_LAT-deep delay line. row_cnt increments. The 8th accept moves to WAIT_ROW. With no handshake, core_vld=0 and core_din holds.
- Capture: when the delay line emits a row tag, buf[idx][0..7] <= core_dout lanes. Capture of row 7 moves WAIT_ROW -> COL.
- COL: on 8 consecutive edges, drive core_din lane k = buf[k][c] for c = 0..7, with core_vld=1 and tag {col,c}. After column 7 is issued, move to WAIT_COL.
- When the delay line emits a column tag: out_data <= core_dout, out_col <= idx, out_valid=1 for one cycle. Column 7 also pulses blk_done, and WAIT_COL -> LOAD on the same edge.
- No arithmetic in this block. Values pass unchanged at W bits, sign preserved. Scaling and rounding belong to the core.
- in_valid outside LOAD is ignored. Data is neither accepted nor lost, and the source holds it.
- Reset mid-block: everything returns to reset values immediately, including out_valid/blk_done. The partial block is discarded, and the next block after reset is processed correctly.

## Timing
- L = CORE_LAT. The first row is accepted at edge t0, with rows back-to-back.
- Row r is issued at t0+r and captured at t0+r+L. Row 7 capture at t0+7+L switches to COL.
- Column c is issued at t0+8+L+c and registered to out_data at t0+8+2L+c. out_valid is visible in the following cycle.
- blk_done/out_valid for column 7 fire at edge t0+15+2L. in_ready rises in the next cycle, so the earliest next accept is t0+16+2L.
- Block period is 16+2L cycles (20 at default). Gaps in in_valid delay the schedule cycle-for-cycle during LOAD only.
- core_vld is high exactly 16 cycles per block.

## Test plan
Bench uses an identity core stub: core_dout = core_din delayed L edges.
- Reset: hold reset 3 cycles -> all outputs 0, in_ready 0. One cycle after release in_ready=1.
- Transpose, L=2: row r lane k = 16*r+k, back-to-back -> out_col c lane k = 16*k+c for c=0..7 on consecutive cycles. blk_done with c=7 at t0+19.
- Gapped input: the same block with 1-cycle in_valid gaps between rows -> identical outputs. core_vld high only on accepted edges. Output shifted by the gap count.
- Held valid: in_valid held high continuously across two blocks -> in_ready 0 from row 8 until after blk_done. The second block's row 0 is accepted at t0+20.
- Sign/param, L=5: row0 = {-8976,-816,0...}, row1 lane0 = 408, others 0 -> col0 = {-8976,408,0...}, col1 lane0 = -816. blk_done at t0+25.
- Reset in COL: assert reset 2 cycles after COL entry -> out_valid/blk_done/busy drop immediately. A fresh transpose block then completes correctly.

Source files
------------

// File: rtl/idct8_2d_seq.sv
// ---------------------------------------------------------------------------
// idct8_2d_seq
//
// Sequences a full 8x8 2-D inverse DCT through one shared 1-D 8-point IDCT
// core. Eight coefficient rows are accepted and sent through the core (row
// pass). The results land in an 8x8 transpose buffer. The buffer columns are
// then replayed through the same core (column pass), and the eight column
// results are streamed out. This block does no arithmetic of its own.
//
// Parameters
//   W        : sample width (signed two's complement) of every lane
//   CORE_LAT : core latency in clock edges (1..8)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_data    in   coefficient row, lane k = bits [k*W +: W] = column k
//   in_valid   in   a row is present on in_data
//   in_ready   out  high in LOAD; a row is taken when in_valid && in_ready
//   core_din   out  registered operand to the IDCT8 core
//   core_vld   out  high for the cycle core_din holds a new operand
//   core_dout  in   core result, CORE_LAT edges after the operand
//   out_data   out  column result, lane k = output pixel row k
//   out_col    out  column index of out_data
//   out_valid  out  one-cycle strobe per column result
//   blk_done   out  pulses with out_valid for column 7
//   busy       out  high in every state except IDLE and LOAD
// ---------------------------------------------------------------------------
module idct8_2d_seq #(
    parameter int W        = 25,
    parameter int CORE_LAT = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [8*W-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [8*W-1:0] core_din,
    output logic           core_vld,
    input  logic [8*W-1:0] core_dout,
    output logic [8*W-1:0] out_data,
    output logic [2:0]     out_col,
    output logic           out_valid,
    output logic           blk_done,
    output logic           busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_ROW,
        COL,
        WAIT_COL
    } state_t;

    // A tag follows each operand through the core so the result can be
    // routed without counting cycles: vld marks a real operand, is_col
    // tells row pass from column pass, idx is the row/column number.
    typedef struct packed {
        logic       vld;
        logic       is_col;
        logic [2:0] idx;
    } tag_t;

    state_t         state;
    state_t         state_nx;
    logic [2:0]     row_cnt;
    logic [2:0]     col_cnt;
    tag_t           dly [CORE_LAT];
    tag_t           tap;
    tag_t           tag_in;
    logic [W-1:0]   tbuf [8][8];
    logic [8*W-1:0] col_vec;
    logic           issue_row;
    logic           issue_col;
    logic           cap_row;
    logic           cap_col;
    logic           last_out;

    // The last delay-line stage lines up with the core result that is
    // sampled at the coming edge.
    assign tap      = dly[CORE_LAT-1];
    assign cap_row  = tap.vld && !tap.is_col;
    assign cap_col  = tap.vld && tap.is_col;
    assign last_out = cap_col && (tap.idx == 3'd7);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode, plus the handshake and issue strobes. Row issue
    // follows the input handshake. Column issue runs once per cycle for
    // the whole COL state. The pass changes when the tag of the last row
    // or last column comes back out of the core.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        issue_row = 1'b0;
        issue_col = 1'b0;
        case (state)
            IDLE: begin
                state_nx = LOAD;
            end
            LOAD: begin
                in_ready  = 1'b1;
                issue_row = in_valid;
                if (in_valid && (row_cnt == 3'd7)) begin
                    state_nx = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                busy = 1'b1;
                if (cap_row && (tap.idx == 3'd7)) begin
                    state_nx = COL;
                end
            end
            COL: begin
                busy      = 1'b1;
                issue_col = 1'b1;
                if (col_cnt == 3'd7) begin
                    state_nx = WAIT_COL;
                end
            end
            WAIT_COL: begin
                busy = 1'b1;
                if (last_out) begin
                    state_nx = LOAD;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Build the tag that goes into the delay line with this cycle's operand.
    always_comb begin
        tag_in = '0;
        if (issue_row) begin
            tag_in = '{vld: 1'b1, is_col: 1'b0, idx: row_cnt};
        end else if (issue_col) begin
            tag_in = '{vld: 1'b1, is_col: 1'b1, idx: col_cnt};
        end
    end

    // Column c of the transpose buffer. Lane k takes row k of the buffer.
    always_comb begin
        col_vec = '0;
        for (int k = 0; k < 8; k++) begin
            col_vec[k*W +: W] = tbuf[k][col_cnt];
        end
    end

    // Operand register, counters, tag delay line and output register.
    // core_din keeps its value when nothing is issued. Only core_vld
    // marks a new operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt   <= '0;
            col_cnt   <= '0;
            core_din  <= '0;
            core_vld  <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            blk_done  <= 1'b0;
            for (int i = 0; i < CORE_LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            core_vld <= issue_row || issue_col;
            if (issue_row) begin
                core_din <= in_data;
                row_cnt  <= row_cnt + 3'd1;
            end else if (issue_col) begin
                core_din <= col_vec;
                col_cnt  <= col_cnt + 3'd1;
            end

            dly[0] <= tag_in;
            for (int i = 1; i < CORE_LAT; i++) begin
                dly[i] <= dly[i-1];
            end

            out_valid <= cap_col;
            blk_done  <= last_out;
            if (cap_col) begin
                out_data <= core_dout;
                out_col  <= tap.idx;
            end
        end
    end

    // The transpose buffer has no reset. It is fully rewritten by the row
    // pass of every block before the column pass reads it.
    always_ff @(posedge clk) begin
        if (cap_row) begin
            for (int k = 0; k < 8; k++) begin
                tbuf[tap.idx][k] <= core_dout[k*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_idct8_2d_seq.sv
// ---------------------------------------------------------------------------
// tb_idct8_2d_seq
//
// Self-checking bench for idct8_2d_seq. Two instances are used: u2 with
// CORE_LAT=2 and u5 with CORE_LAT=5. Each instance drives an identity core
// stub that delays core_din by CORE_LAT edges, so the expected output of a
// block is the transpose of its input rows. Expected columns are pushed to
// a per-instance queue when a block is driven. They are popped and compared
// whenever the instance strobes out_valid.
// ---------------------------------------------------------------------------
module tb_idct8_2d_seq;

    localparam int W = 25;

    typedef logic [8*W-1:0] blk_t [8];

    typedef struct {
        logic [2:0]     col;
        logic [8*W-1:0] data;
        logic           done;
    } exp_t;

    typedef struct {
        int off;
        int mr;
        int mk;
        int gap;
        int exp_lat;
    } vec_t;

    logic           clk;
    logic           reset;

    logic [8*W-1:0] in_data2, core_din2, core_dout2, out_data2;
    logic           in_valid2, in_ready2, core_vld2, out_valid2, blk_done2, busy2;
    logic [2:0]     out_col2;

    logic [8*W-1:0] in_data5, core_din5, core_dout5, out_data5;
    logic           in_valid5, in_ready5, core_vld5, out_valid5, blk_done5, busy5;
    logic [2:0]     out_col5;

    logic [8*W-1:0] pipe2;
    logic [8*W-1:0] pipe5 [4];

    exp_t sb2[$];
    exp_t sb5[$];

    int cyc       = 0;
    int n_tests   = 0;
    int n_fail    = 0;
    int vld_cnt2  = 0;
    int vld_cnt5  = 0;
    int done_cyc2 = -1;
    int done_cyc5 = -1;

    idct8_2d_seq #(.W(W), .CORE_LAT(2)) u2 (
        .clk(clk), .reset(reset),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .core_din(core_din2), .core_vld(core_vld2), .core_dout(core_dout2),
        .out_data(out_data2), .out_col(out_col2), .out_valid(out_valid2),
        .blk_done(blk_done2), .busy(busy2)
    );

    idct8_2d_seq #(.W(W), .CORE_LAT(5)) u5 (
        .clk(clk), .reset(reset),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .core_din(core_din5), .core_vld(core_vld5), .core_dout(core_dout5),
        .out_data(out_data5), .out_col(out_col5), .out_valid(out_valid5),
        .blk_done(blk_done5), .busy(busy5)
    );

    // Clock and edge counter. cyc is the number of rising edges so far.
    // It is only read away from the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Identity core stubs: CORE_LAT-1 register stages, so a result is
    // sampled CORE_LAT edges after its operand was registered.
    always_ff @(posedge clk) begin
        pipe2 <= core_din2;
    end
    assign core_dout2 = pipe2;

    always_ff @(posedge clk) begin
        pipe5[0] <= core_din5;
        for (int i = 1; i < 4; i++) begin
            pipe5[i] <= pipe5[i-1];
        end
    end
    assign core_dout5 = pipe5[3];

    task automatic checkOutput(input string name, input logic [8*W-1:0] act,
                               input logic [8*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Output monitors. They sample at the falling edge and score each
    // out_valid strobe against the queue of expected columns.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core_vld2) vld_cnt2++;
            if (out_valid2) begin
                if (blk_done2) done_cyc2 = cyc;
                if (sb2.size() == 0) begin
                    checkOutput("u2_unexpected_out", 1, 0);
                end else begin
                    e = sb2.pop_front();
                    checkOutput("u2_out_col", out_col2, e.col);
                    checkOutput("u2_out_data", out_data2, e.data);
                    checkOutput("u2_blk_done", blk_done2, e.done);
                end
            end else if (blk_done2) begin
                checkOutput("u2_done_without_valid", 1, 0);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core_vld5) vld_cnt5++;
            if (out_valid5) begin
                if (blk_done5) done_cyc5 = cyc;
                if (sb5.size() == 0) begin
                    checkOutput("u5_unexpected_out", 1, 0);
                end else begin
                    e = sb5.pop_front();
                    checkOutput("u5_out_col", out_col5, e.col);
                    checkOutput("u5_out_data", out_data5, e.data);
                    checkOutput("u5_blk_done", blk_done5, e.done);
                end
            end else if (blk_done5) begin
                checkOutput("u5_done_without_valid", 1, 0);
            end
        end
    end

    task automatic drive(input int which, input logic v, input logic [8*W-1:0] d);
        if (which == 5) begin
            in_valid5 = v;
            in_data5  = d;
        end else begin
            in_valid2 = v;
            in_data2  = d;
        end
    endtask

    function automatic logic rdy(input int which);
        return (which == 5) ? in_ready5 : in_ready2;
    endfunction

    // Drives one block of eight rows and queues its expected columns.
    // gap idle cycles are inserted between rows. With hold set, in_valid
    // stays high after the last row and next_data is presented. t0 is
    // the edge at which row 0 was accepted.
    task automatic applyStimulus(input int which, input blk_t rows, input blk_t cols,
                                 input int gap, input bit hold,
                                 input logic [8*W-1:0] next_data, output int t0);
        exp_t e;
        int   n;
        t0 = -1;
        for (int c = 0; c < 8; c++) begin
            e.col  = 3'(c);
            e.data = cols[c];
            e.done = (c == 7);
            if (which == 5) sb5.push_back(e);
            else            sb2.push_back(e);
        end
        for (int r = 0; r < 8; r++) begin
            if (r > 0 && gap > 0) begin
                drive(which, 1'b0, rows[r-1]);
                repeat (gap) @(posedge clk);
                #1;
            end
            drive(which, 1'b1, rows[r]);
            n = 0;
            while (!rdy(which) && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 200) checkOutput("in_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
            if (r == 0) t0 = cyc;
        end
        if (hold) drive(which, 1'b1, next_data);
        else      drive(which, 1'b0, rows[7]);
    endtask

    // Waits (bounded) for the block started at t0 to signal blk_done, then
    // checks its latency and the number of core operands it issued.
    task automatic waitDone(input int which, input int t0, input int exp_lat,
                            input string name);
        int n = 0;
        while (((which == 5) ? done_cyc5 : done_cyc2) < t0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (which == 5) begin
            checkOutput({name, "_done_latency"}, done_cyc5 - t0, exp_lat);
            checkOutput({name, "_core_vld_count"}, vld_cnt5, 16);
            vld_cnt5 = 0;
        end else begin
            checkOutput({name, "_done_latency"}, done_cyc2 - t0, exp_lat);
            checkOutput({name, "_core_vld_count"}, vld_cnt2, 16);
            vld_cnt2 = 0;
        end
    endtask

    // Rows follow value = off + mr*row + mk*lane. The expected column c,
    // lane k, is therefore off + mr*k + mk*c.
    task automatic makeBlock(input vec_t v, output blk_t rows, output blk_t cols);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                rows[r][k*W +: W] = W'(v.off + v.mr * r + v.mk * k);
                cols[r][k*W +: W] = W'(v.off + v.mr * k + v.mk * r);
            end
        end
    endtask

    initial begin
        vec_t tbl [4];
        blk_t rows, cols, rows_b, cols_b;
        int   t0, t0b;

        tbl[0] = '{off: 0,        mr: 16,    mk: 1,       gap: 0, exp_lat: 19};
        tbl[1] = '{off: 0,        mr: 16,    mk: 1,       gap: 1, exp_lat: 26};
        tbl[2] = '{off: -1000,    mr: -3,    mk: 7,       gap: 0, exp_lat: 19};
        tbl[3] = '{off: 16000000, mr: 1000,  mk: -100000, gap: 2, exp_lat: 33};

        reset     = 1'b1;
        in_valid2 = 1'b0;
        in_data2  = '0;
        in_valid5 = 1'b0;
        in_data5  = '0;

        // Reset state and release.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready2, 0);
        checkOutput("rst_out_valid", out_valid2, 0);
        checkOutput("rst_blk_done", blk_done2, 0);
        checkOutput("rst_busy", busy2, 0);
        checkOutput("rst_core_vld", core_vld2, 0);
        checkOutput("rst_core_din", core_din2, 0);
        checkOutput("rst_out_data", out_data2, 0);
        checkOutput("rst_out_col", out_col2, 0);
        checkOutput("rst_in_ready_u5", in_ready5, 0);
        checkOutput("rst_busy_u5", busy5, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("idle_in_ready", in_ready2, 0);
        @(posedge clk);
        #1;
        checkOutput("load_in_ready", in_ready2, 1);
        checkOutput("load_busy", busy2, 0);

        // Table-driven blocks on the CORE_LAT=2 instance.
        for (int i = 0; i < 4; i++) begin
            makeBlock(tbl[i], rows, cols);
            applyStimulus(2, rows, cols, tbl[i].gap, 1'b0, '0, t0);
            checkOutput("busy_after_load", busy2, 1);
            waitDone(2, t0, tbl[i].exp_lat, $sformatf("tbl%0d", i));
        end

        // in_valid held high across two blocks: the second block must wait
        // for the first to finish, and its row 0 is taken 20 edges later.
        makeBlock(tbl[0], rows, cols);
        makeBlock(tbl[2], rows_b, cols_b);
        applyStimulus(2, rows, cols, 0, 1'b1, rows_b[0], t0);
        checkOutput("held_in_ready_low", in_ready2, 0);
        waitDone(2, t0, 19, "held_a");
        applyStimulus(2, rows_b, cols_b, 0, 1'b0, '0, t0b);
        checkOutput("held_b_start", t0b - t0, 20);
        waitDone(2, t0b, 19, "held_b");

        // Signed values through the CORE_LAT=5 instance.
        for (int r = 0; r < 8; r++) begin
            rows[r] = '0;
            cols[r] = '0;
        end
        rows[0][0 +: W] = W'(-8976);
        rows[0][W +: W] = W'(-816);
        rows[1][0 +: W] = W'(408);
        cols[0][0 +: W] = W'(-8976);
        cols[0][W +: W] = W'(408);
        cols[1][0 +: W] = W'(-816);
        applyStimulus(5, rows, cols, 0, 1'b0, '0, t0);
        waitDone(5, t0, 25, "sign_l5");

        // Reset two cycles after entering COL, then a fresh block.
        makeBlock(tbl[0], rows, cols);
        applyStimulus(2, rows, cols, 0, 1'b0, '0, t0);
        while (cyc < t0 + 11) begin
            @(posedge clk);
            #1;
        end
        checkOutput("col_busy_before_reset", busy2, 1);
        checkOutput("col_core_vld_before_reset", core_vld2, 1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid2, 0);
        checkOutput("midrst_blk_done", blk_done2, 0);
        checkOutput("midrst_busy", busy2, 0);
        checkOutput("midrst_core_vld", core_vld2, 0);
        checkOutput("midrst_in_ready", in_ready2, 0);
        sb2.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        vld_cnt2 = 0;
        applyStimulus(2, rows, cols, 0, 1'b0, '0, t0);
        waitDone(2, t0, 19, "after_reset");

        repeat (10) @(posedge clk);
        #1;
        checkOutput("sb2_drained", sb2.size(), 0);
        checkOutput("sb5_drained", sb5.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
